output_buffer: RTL

History and output buffer on the decompressed-byte side of the LZ4 decompressor, the opposite end from the compressed-byte input buffer. The sequence decoder pushes literal bytes and issues back-reference (match) copy commands. The block expands matches byte-by-byte from its own history RAM. It streams all produced bytes out in order through a valid/ready drain port.

---
 rtl/lz4_pkg.sv | 15 +
 rtl/output_buffer_history_ram.sv | 49 ++++
 rtl/output_buffer.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/lz4_pkg.sv
// Shared definitions for the LZ4 decompressor datapath: default widths and
// the match-copy FSM state type.
package lz4_pkg;

  localparam int unsigned WORD_SIZE    = 8;
  localparam int unsigned ADDRESS_SIZE = 16;
  localparam int unsigned LENGTH_SIZE  = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COPY_RD = 2'd1,
    COPY_WR = 2'd2
  } copy_state_t;

endpackage

// File: rtl/output_buffer_history_ram.sv
// History RAM: one write port and two registered read ports, one feeding the
// match-copy engine and one feeding the output drain register.
module history_ram
  import lz4_pkg::*;
#(
  parameter int unsigned word_size    = WORD_SIZE,
  parameter int unsigned address_size = ADDRESS_SIZE
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_en,
  input  logic [address_size-1:0] wr_addr,
  input  logic [word_size-1:0]    wr_data,
  input  logic                    copy_rd_en,
  input  logic [address_size-1:0] copy_rd_addr,
  output logic [word_size-1:0]    copy_rd_data,
  input  logic                    drain_rd_en,
  input  logic [address_size-1:0] drain_rd_addr,
  output logic [word_size-1:0]    drain_rd_data
);

  localparam int unsigned MEMORY_SIZE = 2 ** address_size;

  logic [word_size-1:0] mem [MEMORY_SIZE];

  // Storage itself is never reset; only the read registers are.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      copy_rd_data <= '0;
    end else if (copy_rd_en) begin
      copy_rd_data <= mem[copy_rd_addr];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drain_rd_data <= '0;
    end else if (drain_rd_en) begin
      drain_rd_data <= mem[drain_rd_addr];
    end
  end

endmodule

// File: rtl/output_buffer.sv
// LZ4 output buffer: accepts literals and back-reference copies, expands
// matches from its own history RAM and streams bytes out over valid/ready.
module output_buffer
  import lz4_pkg::*;
#(
  parameter int unsigned word_size    = WORD_SIZE,
  parameter int unsigned address_size = ADDRESS_SIZE,
  parameter int unsigned length_size  = LENGTH_SIZE
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    literal_write,
  input  logic [word_size-1:0]    literal_data,
  input  logic                    match_start,
  input  logic [address_size-1:0] match_offset,
  input  logic [length_size-1:0]  match_length,
  output logic                    busy,
  output logic                    full,
  output logic                    error,
  output logic [word_size-1:0]    data_out,
  output logic                    data_valid,
  input  logic                    data_ready,
  output logic [address_size:0]   pending_count
);

  localparam logic [address_size:0]   FULL_COUNT = {1'b1, {address_size{1'b0}}};
  localparam logic [address_size-1:0] DEPTH_MAX  = '1;
  localparam logic [length_size-1:0]  LEN_ONE    = length_size'(1);

  copy_state_t state;

  logic [address_size-1:0] write_pointer;
  logic [address_size-1:0] read_pointer;
  logic [address_size-1:0] src_pointer;
  logic [address_size-1:0] history_depth;
  logic [length_size-1:0]  remaining;

  logic                    cmd_conflict;
  logic                    literal_accept;
  logic                    literal_reject;
  logic                    match_in_idle;
  logic                    match_bad_offset;
  logic                    match_accept;
  logic                    match_reject;
  logic                    error_set;
  logic                    copy_write;
  logic                    ram_wr_en;
  logic [word_size-1:0]    ram_wr_data;
  logic                    copy_rd_en;
  logic [word_size-1:0]    copy_rd_data;
  logic                    drain_load;

  assign busy = (state != IDLE);
  assign full = (pending_count == FULL_COUNT);

  always_comb begin
    cmd_conflict     = literal_write && match_start;
    literal_accept   = literal_write && !match_start && !busy && !full;
    literal_reject   = literal_write && (busy || full);
    match_in_idle    = match_start && !literal_write && !busy;
    match_bad_offset = (match_offset == '0) || (match_offset > history_depth);
    // A zero-length match is a silent no-op even with a bad offset.
    match_accept     = match_in_idle && (match_length != '0) && !match_bad_offset;
    match_reject     = match_in_idle && (match_length != '0) && match_bad_offset;
    error_set        = cmd_conflict || literal_reject || (match_start && busy) || match_reject;

    copy_rd_en  = (state == COPY_RD);
    copy_write  = (state == COPY_WR) && !full;
    ram_wr_en   = literal_accept || copy_write;
    ram_wr_data = copy_write ? copy_rd_data : literal_data;

    drain_load  = (pending_count != '0) && (!data_valid || data_ready);
  end

  history_ram #(
    .word_size   (word_size),
    .address_size(address_size)
  ) u_history_ram (
    .clk          (clk),
    .reset        (reset),
    .wr_en        (ram_wr_en),
    .wr_addr      (write_pointer),
    .wr_data      (ram_wr_data),
    .copy_rd_en   (copy_rd_en),
    .copy_rd_addr (src_pointer),
    .copy_rd_data (copy_rd_data),
    .drain_rd_en  (drain_load),
    .drain_rd_addr(read_pointer),
    .drain_rd_data(data_out)
  );

  // Match-copy engine: one read then one write per byte, so a copy whose
  // source overlaps its own output sees each freshly written byte.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      src_pointer <= '0;
      remaining   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (match_accept) begin
            src_pointer <= write_pointer - match_offset;
            remaining   <= match_length;
            state       <= COPY_RD;
          end
        end
        COPY_RD: begin
          state <= COPY_WR;
        end
        COPY_WR: begin
          if (!full) begin
            src_pointer <= src_pointer + 1'b1;
            remaining   <= remaining - 1'b1;
            state       <= (remaining == LEN_ONE) ? IDLE : COPY_RD;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      write_pointer <= '0;
      read_pointer  <= '0;
      history_depth <= '0;
      pending_count <= '0;
      data_valid    <= 1'b0;
      error         <= 1'b0;
    end else begin
      if (error_set) begin
        error <= 1'b1;
      end

      if (ram_wr_en) begin
        write_pointer <= write_pointer + 1'b1;
        if (history_depth != DEPTH_MAX) begin
          history_depth <= history_depth + 1'b1;
        end
      end

      if (drain_load) begin
        read_pointer <= read_pointer + 1'b1;
        data_valid   <= 1'b1;
      end else if (data_valid && data_ready) begin
        data_valid <= 1'b0;
      end

      case ({ram_wr_en, drain_load})
        2'b10:   pending_count <= pending_count + 1'b1;
        2'b01:   pending_count <= pending_count - 1'b1;
        default: pending_count <= pending_count;
      endcase
    end
  end

endmodule
